snake_step_sched: RTL



---
 rtl/snake_step_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/snake_step_sched.sv
// Game-step scheduler for the snake core: emits a one-cycle Step enable whose period
// shrinks with snake length, and arbitrates button pulses into a 2-deep heading queue.
module snake_step_sched #(
  parameter int CNT_W       = 27,
  parameter int BASE_PERIOD = 67108864,
  parameter int STEP_DEC    = 4194304,
  parameter int MIN_PERIOD  = 16777216
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic       Run,
  input  logic [3:0] Length,
  output logic       Step,
  output logic [1:0] Dir,
  output logic [1:0] QCount,
  output logic       Rejected
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int PW = CNT_W + 4;
  localparam logic [PW-1:0] BASE_W = PW'(BASE_PERIOD);
  localparam logic [PW-1:0] MIN_W  = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] STEP_W = PW'(STEP_DEC);

  function automatic logic is_vertical(input dir_e d);
    return (d == DIR_UP) || (d == DIR_DOWN);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             run_q, run_d;
  logic             step_q, step_d;
  logic             rejected_q, rejected_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       qcount_q, qcount_d;
  dir_e             q0_q, q0_d;   // head
  dir_e             q1_q, q1_d;   // second entry

  logic [PW-1:0]    prod;
  logic [CNT_W-1:0] p_new, p_eff;
  logic             start, step_edge, pop, push, reject;
  logic             win_valid, conflict, full_block;
  dir_e             win_dir, ref_dir;

  assign prod  = PW'(Length) * STEP_W;
  assign p_new = (prod > (BASE_W - MIN_W)) ? CNT_W'(MIN_W) : CNT_W'(BASE_W - prod);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    win_valid = Up | Down | Left | Right;
    win_dir   = DIR_RIGHT;
    if (Up)        win_dir = DIR_UP;
    else if (Down) win_dir = DIR_DOWN;
    else if (Left) win_dir = DIR_LEFT;

    ref_dir = dir_q;
    if (qcount_q == 2'd2)      ref_dir = q1_q;
    else if (qcount_q == 2'd1) ref_dir = q0_q;

    // A period starts on the Run rising edge, so its length is taken live that cycle.
    start      = Run && !run_q;
    p_eff      = start ? p_new : period_q;
    step_edge  = Run && (cnt_q == p_eff - 1'b1);
    pop        = step_edge && (qcount_q != 2'd0);
    conflict   = is_vertical(win_dir) == is_vertical(ref_dir);
    full_block = (qcount_q == 2'd2) && !pop;
    push       = Run && win_valid && !conflict && !full_block;
    reject     = Run && win_valid && (conflict || full_block);
  end

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    run_d      = Run;
    step_d     = 1'b0;
    rejected_d = 1'b0;
    dir_d      = dir_q;
    qcount_d   = qcount_q;
    q0_d       = q0_q;
    q1_d       = q1_q;

    if (!Run) begin
      cnt_d    = '0;
      qcount_d = 2'd0;
    end else begin
      if (start) period_d = p_new;
      if (step_edge) begin
        cnt_d    = '0;
        step_d   = 1'b1;
        period_d = p_new;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      rejected_d = reject;

      if (pop) begin
        dir_d = q0_q;
        q0_d  = q1_q;
      end
      // Push lands at the tail slot left after any pop in the same cycle.
      if (push) begin
        if ((qcount_q - {1'b0, pop}) == 2'd0) q0_d = win_dir;
        else                                  q1_d = win_dir;
      end
      qcount_d = qcount_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q      <= '0;
      period_q   <= CNT_W'(BASE_W);
      run_q      <= 1'b0;
      step_q     <= 1'b0;
      rejected_q <= 1'b0;
      dir_q      <= DIR_RIGHT;
      qcount_q   <= 2'd0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      run_q      <= run_d;
      step_q     <= step_d;
      rejected_q <= rejected_d;
      dir_q      <= dir_d;
      qcount_q   <= qcount_d;
    end
  end

  // NOTE: queue storage is not reset; qcount_q gates every read, so stale entries are never used.
  always_ff @(posedge Clk) begin
    q0_q <= q0_d;
    q1_q <= q1_d;
  end

  assign Step     = step_q;
  assign Dir      = dir_q;
  assign QCount   = qcount_q;
  assign Rejected = rejected_q;

endmodule
